cpm_topk_sched: RTL and testbench

- Sequencer that feeds the top-K sorting engine from a candidate-score SRAM, one query at a time.
- Per query: pulses the sorter's synchronous clear, then streams CAND_NUM scores with their candidate indices as info.
- Waits for the sorter's top-K valid, then presents a per-query result handshake so downstream can read the sorter's K-entry outputs.
- Sits between the CPM config/control registers and the top-K engine.

---
 rtl/cpm_topk_sched_if.sv | 44 ++++
 rtl/cpm_topk_sched.sv | 132 +++++++++++++
 tb/tb_cpm_topk_sched.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpm_topk_sched_if.sv
// rtl/cpm_topk_sched_if.sv - config, SRAM, sorter and result signals of the top-K sequencer
interface cpm_topk_sched_if #(
    parameter int DATA_DW = 8,
    parameter int INFO_DW = 8,
    parameter int ADDR_W  = 12,
    parameter int CNT_W   = 8
);
    logic               CFG_VLD;
    logic               CFG_RDY;
    logic [CNT_W-1:0]   CFG_QRY_NUM;
    logic [CNT_W-1:0]   CFG_CAND_NUM;
    logic [ADDR_W-1:0]  CFG_BASE_ADDR;
    logic [ADDR_W-1:0]  CFG_STRIDE;
    logic               MEM_RD_VLD;
    logic [ADDR_W-1:0]  MEM_RD_ADDR;
    logic [DATA_DW-1:0] MEM_RD_DAT;
    logic               SORT_CLR;
    logic               SORT_DAT_VLD;
    logic               SORT_DAT_RDY;
    logic               SORT_DAT_LST;
    logic [DATA_DW-1:0] SORT_DAT_DAT;
    logic [INFO_DW-1:0] SORT_DAT_INF;
    logic               TOPK_DAT_VLD;
    logic               RES_VLD;
    logic               RES_RDY;
    logic [CNT_W-1:0]   RES_QRY;
    logic               RES_EMPTY;
    logic               BUSY;
    logic               DONE;

    modport master (
        input  CFG_VLD, CFG_QRY_NUM, CFG_CAND_NUM, CFG_BASE_ADDR, CFG_STRIDE,
               MEM_RD_DAT, SORT_DAT_RDY, TOPK_DAT_VLD, RES_RDY,
        output CFG_RDY, MEM_RD_VLD, MEM_RD_ADDR, SORT_CLR, SORT_DAT_VLD, SORT_DAT_LST,
               SORT_DAT_DAT, SORT_DAT_INF, RES_VLD, RES_QRY, RES_EMPTY, BUSY, DONE
    );

    modport slave (
        output CFG_VLD, CFG_QRY_NUM, CFG_CAND_NUM, CFG_BASE_ADDR, CFG_STRIDE,
               MEM_RD_DAT, SORT_DAT_RDY, TOPK_DAT_VLD, RES_RDY,
        input  CFG_RDY, MEM_RD_VLD, MEM_RD_ADDR, SORT_CLR, SORT_DAT_VLD, SORT_DAT_LST,
               SORT_DAT_DAT, SORT_DAT_INF, RES_VLD, RES_QRY, RES_EMPTY, BUSY, DONE
    );
endinterface

// File: rtl/cpm_topk_sched.sv
// rtl/cpm_topk_sched.sv - per-query sequencer streaming SRAM scores into the top-K sorter
module cpm_topk_sched #(
    parameter int DATA_DW = 8,
    parameter int INFO_DW = 8,
    parameter int ADDR_W  = 12,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    cpm_topk_sched_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_WAIT, S_OUT, S_FIN} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   qry_num_q, cand_num_q, qry_q, rd_idx_q, infl_idx_q;
    logic [ADDR_W-1:0]  stride_q, qbase_q;
    logic               infl_q;
    logic [DATA_DW-1:0] buf_dat_q [2];
    logic [CNT_W-1:0]   buf_idx_q [2];
    logic               wptr_q, rptr_q;
    logic [1:0]         cnt_q;

    logic       accept, head_vld, head_lst, pop, issue, res_hs, last_qry;
    logic [2:0] occ_next;

    // Read credit counts both buffered entries and the read still in flight,
    // so the 2-entry buffer can never overflow with the fixed 1-cycle SRAM.
    always_comb begin
        accept   = bus.CFG_VLD && (state_q == S_IDLE);
        head_vld = (state_q == S_RUN) && (cnt_q != 2'd0);
        head_lst = buf_idx_q[rptr_q] == (cand_num_q - CNT_W'(1));
        pop      = head_vld && bus.SORT_DAT_RDY;
        occ_next = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
        issue    = (state_q == S_RUN) && (rd_idx_q < cand_num_q) && (occ_next < 3'd2);
        res_hs   = (state_q == S_OUT) && bus.RES_RDY;
        last_qry = (qry_q + CNT_W'(1)) == qry_num_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (bus.CFG_QRY_NUM == '0) ? S_FIN : S_CLR;
            S_CLR:   state_d = (cand_num_q == '0) ? S_WAIT : S_RUN;
            S_RUN:   if (pop && head_lst) state_d = S_WAIT;
            S_WAIT:  if ((cand_num_q == '0) || bus.TOPK_DAT_VLD) state_d = S_OUT;
            S_OUT:   if (res_hs) state_d = last_qry ? S_FIN : S_CLR;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.CFG_RDY      = (state_q == S_IDLE);
        bus.BUSY         = (state_q != S_IDLE);
        bus.SORT_CLR     = (state_q == S_CLR);
        bus.MEM_RD_VLD   = issue;
        bus.MEM_RD_ADDR  = issue ? (qbase_q + ADDR_W'(rd_idx_q)) : '0;
        bus.SORT_DAT_VLD = head_vld;
        bus.SORT_DAT_DAT = head_vld ? buf_dat_q[rptr_q] : '0;
        bus.SORT_DAT_INF = head_vld ? INFO_DW'(buf_idx_q[rptr_q]) : '0;
        bus.SORT_DAT_LST = head_vld && head_lst;
        bus.RES_VLD      = (state_q == S_OUT);
        bus.RES_QRY      = (state_q == S_OUT) ? qry_q : '0;
        bus.RES_EMPTY    = (state_q == S_OUT) && (cand_num_q == '0);
        bus.DONE         = (state_q == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qry_num_q  <= '0;
            cand_num_q <= '0;
            stride_q   <= '0;
            qbase_q    <= '0;
            qry_q      <= '0;
            rd_idx_q   <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= '0;
        end else if (clear) begin
            qry_q    <= '0;
            rd_idx_q <= '0;
            infl_q   <= 1'b0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                qry_num_q  <= bus.CFG_QRY_NUM;
                cand_num_q <= bus.CFG_CAND_NUM;
                stride_q   <= bus.CFG_STRIDE;
                qbase_q    <= bus.CFG_BASE_ADDR;
                qry_q      <= '0;
            end
            if (state_q == S_CLR) begin
                rd_idx_q <= '0;
            end else if (issue) begin
                rd_idx_q <= rd_idx_q + CNT_W'(1);
            end
            infl_q     <= issue;
            infl_idx_q <= rd_idx_q;
            if (infl_q) wptr_q <= ~wptr_q;
            if (pop)    rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
            // Query base advances by stride, giving BASE + q*STRIDE modulo the address width.
            if (res_hs) begin
                qry_q   <= qry_q + CNT_W'(1);
                qbase_q <= qbase_q + stride_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (infl_q) begin
            buf_dat_q[wptr_q] <= bus.MEM_RD_DAT;
            buf_idx_q[wptr_q] <= infl_idx_q;
        end
    end
endmodule

// File: tb/tb_cpm_topk_sched.sv
// tb/tb_cpm_topk_sched.sv - self-checking bench for the top-K query sequencer
module tb_cpm_topk_sched;
    localparam int DW = 8, IW = 8, AW = 12, CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    cpm_topk_sched_if #(.DATA_DW(DW), .INFO_DW(IW), .ADDR_W(AW), .CNT_W(CW)) bus();

    cpm_topk_sched #(.DATA_DW(DW), .INFO_DW(IW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    // SRAM with 1-cycle read latency and a sorter whose result-valid rises after LST
    logic [7:0] sram [4096];
    logic [7:0] mem_dat_q = 8'h00;
    logic       topk_q = 1'b0;
    always @(posedge clk) mem_dat_q <= bus.MEM_RD_VLD ? sram[bus.MEM_RD_ADDR] : 8'h00;
    always @(posedge clk) begin
        if (bus.SORT_CLR) topk_q <= 1'b0;
        else if (bus.SORT_DAT_VLD && bus.SORT_DAT_RDY && bus.SORT_DAT_LST) topk_q <= 1'b1;
    end
    assign bus.MEM_RD_DAT   = mem_dat_q;
    assign bus.TOPK_DAT_VLD = topk_q;

    int errors = 0, checks = 0, cyc = 0;
    int exp_addr[$], exp_dat[$], exp_inf[$], exp_lst[$], exp_qry[$], exp_emp[$];
    int clr_left = 0, done_pend = 0, active = 0, last_evt = -10, occ = 0;
    int rd_log[$], dat_log[$], inf_log[$], pop_cyc[$], qry_log[$], emp_log[$], res_lat[$];
    int lst_cnt = 0, clr_cnt = 0, done_cnt = 0, first_vld = -1, first_clr = -1;
    int srdy_mode = 0, res_delay = 0, res_wait = 0, res_start = 0;
    logic hold_dat = 1'b0, hold_res = 1'b0, prev_rv = 1'b0;
    logic [16:0] hold_dvec;
    logic [8:0]  hold_rvec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) chk(name, got[k], exp[k]);
    endtask

    // Whole-job expectation straight from the addressing and indexing rules
    task automatic model_job(input int qn, input int cn, input int base, input int stride);
        for (int q = 0; q < qn; q++) begin
            for (int i = 0; i < cn; i++) begin
                int a;
                a = (base + q * stride + i) % 4096;
                exp_addr.push_back(a);
                exp_dat.push_back(int'(sram[a]));
                exp_inf.push_back(i % 256);
                exp_lst.push_back(i == cn - 1);
            end
            exp_qry.push_back(q);
            exp_emp.push_back(cn == 0);
        end
        clr_left += qn;
    endtask

    task automatic flush_model();
        exp_addr.delete(); exp_dat.delete(); exp_inf.delete(); exp_lst.delete();
        exp_qry.delete(); exp_emp.delete();
        clr_left = 0; done_pend = 0; active = 0; occ = 0;
        hold_dat = 1'b0; hold_res = 1'b0; prev_rv = 1'b0;
    endtask

    task automatic monitor();
        logic pop;
        int   e0, e1, e2;
        pop = bus.SORT_DAT_VLD && bus.SORT_DAT_RDY;
        if (hold_dat) begin
            chk("dat_hold_vld", bus.SORT_DAT_VLD, 1);
            chk("dat_hold_val", {bus.SORT_DAT_DAT, bus.SORT_DAT_INF, bus.SORT_DAT_LST}, hold_dvec);
        end
        hold_dat  = bus.SORT_DAT_VLD && !bus.SORT_DAT_RDY;
        hold_dvec = {bus.SORT_DAT_DAT, bus.SORT_DAT_INF, bus.SORT_DAT_LST};
        if (hold_res) begin
            chk("res_hold_vld", bus.RES_VLD, 1);
            chk("res_hold_val", {bus.RES_QRY, bus.RES_EMPTY}, hold_rvec);
        end
        hold_res  = bus.RES_VLD && !bus.RES_RDY;
        hold_rvec = {bus.RES_QRY, bus.RES_EMPTY};

        chk("busy", bus.BUSY, active != 0);
        chk("cfg_rdy", bus.CFG_RDY, active == 0);
        if (bus.CFG_VLD && bus.CFG_RDY) begin
            model_job(bus.CFG_QRY_NUM, bus.CFG_CAND_NUM, bus.CFG_BASE_ADDR, bus.CFG_STRIDE);
            active = 1; done_pend++; last_evt = cyc;
        end
        if (bus.MEM_RD_VLD) begin
            occ++;
            rd_log.push_back(bus.MEM_RD_ADDR);
            if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
            else begin e0 = exp_addr.pop_front(); chk("rd_addr", bus.MEM_RD_ADDR, e0); end
        end
        if (bus.SORT_DAT_VLD && first_vld < 0) first_vld = cyc;
        if (pop) begin
            occ--;
            dat_log.push_back(bus.SORT_DAT_DAT);
            inf_log.push_back(bus.SORT_DAT_INF);
            pop_cyc.push_back(cyc);
            if (bus.SORT_DAT_LST) lst_cnt++;
            if (exp_dat.size() == 0) chk("sort_unexpected", 1, 0);
            else begin
                e0 = exp_dat.pop_front(); e1 = exp_inf.pop_front(); e2 = exp_lst.pop_front();
                chk("sort_dat", bus.SORT_DAT_DAT, e0);
                chk("sort_inf", bus.SORT_DAT_INF, e1);
                chk("sort_lst", bus.SORT_DAT_LST, e2);
            end
        end
        chk("occ_le2", occ <= 2, 1);
        if (bus.SORT_CLR) begin
            clr_cnt++;
            if (first_clr < 0) first_clr = cyc;
            chk("clr_excl", bus.SORT_DAT_VLD || bus.RES_VLD, 0);
            chk("clr_expected", clr_left > 0, 1);
            if (clr_left > 0) clr_left--;
        end
        if (bus.RES_VLD && !prev_rv) res_start = cyc;
        prev_rv = bus.RES_VLD;
        if (bus.RES_VLD && bus.RES_RDY) begin
            qry_log.push_back(bus.RES_QRY);
            emp_log.push_back(bus.RES_EMPTY);
            res_lat.push_back(cyc - res_start);
            last_evt = cyc;
            if (exp_qry.size() == 0) chk("res_unexpected", 1, 0);
            else begin
                e0 = exp_qry.pop_front(); e1 = exp_emp.pop_front();
                chk("res_qry", bus.RES_QRY, e0);
                chk("res_empty", bus.RES_EMPTY, e1);
            end
        end
        if (bus.DONE) begin
            done_cnt++;
            chk("done_expected", done_pend > 0, 1);
            chk("done_time", cyc, last_evt + 1);
            chk("done_drained", exp_addr.size() + exp_dat.size() + exp_qry.size() + clr_left, 0);
            if (done_pend > 0) done_pend--;
            active = 0;
        end
    endtask

    initial begin
        bus.SORT_DAT_RDY = 1'b1;
        bus.RES_RDY      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.SORT_DAT_RDY = (srdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (bus.RES_VLD) res_wait++; else res_wait = 0;
            bus.RES_RDY = res_wait > res_delay;
            #1;
            if (!rst_n || clear) flush_model();
            else monitor();
        end
    end

    task automatic reset_logs();
        rd_log.delete(); dat_log.delete(); inf_log.delete(); pop_cyc.delete();
        qry_log.delete(); emp_log.delete(); res_lat.delete();
        lst_cnt = 0; clr_cnt = 0; done_cnt = 0; first_vld = -1; first_clr = -1;
    endtask

    task automatic start_job(input int qn, input int cn, input int base, input int stride);
        @(negedge clk);
        bus.CFG_QRY_NUM   = CW'(qn);
        bus.CFG_CAND_NUM  = CW'(cn);
        bus.CFG_BASE_ADDR = AW'(base);
        bus.CFG_STRIDE    = AW'(stride);
        bus.CFG_VLD       = 1'b1;
        @(negedge clk);
        bus.CFG_VLD = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
        chk({name, "_done_timeout"}, done_cnt != 0, 1);
        @(negedge clk);
    endtask

    task automatic idle_outputs(input string name);
        chk({name, "_cfg_rdy"}, bus.CFG_RDY, 1);
        chk({name, "_busy"}, bus.BUSY, 0);
        chk({name, "_done"}, bus.DONE, 0);
        chk({name, "_sort_vld"}, bus.SORT_DAT_VLD, 0);
        chk({name, "_res_vld"}, bus.RES_VLD, 0);
        chk({name, "_rd_vld"}, bus.MEM_RD_VLD, 0);
        chk({name, "_sort_clr"}, bus.SORT_CLR, 0);
    endtask

    initial begin
        int e[$];
        int t;
        for (int i = 0; i < 4096; i++) sram[i] = 8'((i * 7 + 3) % 251);
        sram[12'h010] = 8'd5; sram[12'h011] = 8'd9; sram[12'h012] = 8'd3; sram[12'h013] = 8'd7;
        bus.CFG_VLD = 1'b0; bus.CFG_QRY_NUM = '0; bus.CFG_CAND_NUM = '0;
        bus.CFG_BASE_ADDR = '0; bus.CFG_STRIDE = '0;
        repeat (3) @(negedge clk);
        #1 idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single query, four scores
        reset_logs();
        start_job(1, 4, 'h010, 0);
        wait_done("t1");
        e = '{5, 9, 3, 7};      chk_q("t1_dat", dat_log, e);
        e = '{0, 1, 2, 3};      chk_q("t1_inf", inf_log, e);
        e = '{0};               chk_q("t1_qry", qry_log, e);
        chk("t1_lst_cnt", lst_cnt, 1);
        chk("t1_clr_cnt", clr_cnt, 1);
        chk("t1_first_vld", first_vld, first_clr + 3);
        for (int k = 1; k < pop_cyc.size(); k++) chk("t1_consecutive", pop_cyc[k], pop_cyc[0] + k);

        // three queries with stride
        reset_logs();
        start_job(3, 2, 'h100, 'h020);
        wait_done("t2");
        e = '{'h100, 'h101, 'h120, 'h121, 'h140, 'h141}; chk_q("t2_addr", rd_log, e);
        e = '{0, 1, 2};         chk_q("t2_qry", qry_log, e);
        chk("t2_clr_cnt", clr_cnt, 3);

        // sorter backpressure 1,0,0,1
        reset_logs();
        srdy_mode = 1;
        start_job(2, 5, 'h200, 'h007);
        wait_done("t3");
        srdy_mode = 0;
        chk("t3_dat_cnt", dat_log.size(), 10);
        chk("t3_clr_cnt", clr_cnt, 2);

        // zero candidates, then zero queries
        reset_logs();
        start_job(2, 0, 'h300, 'h010);
        wait_done("t4");
        chk("t4_reads", rd_log.size(), 0);
        e = '{1, 1};            chk_q("t4_empty", emp_log, e);
        e = '{0, 1};            chk_q("t4_qry", qry_log, e);
        reset_logs();
        start_job(0, 3, 'h000, 'h000);
        wait_done("t4b");
        chk("t4b_clr_cnt", clr_cnt, 0);
        chk("t4b_done_cnt", done_cnt, 1);

        // downstream holds RES_RDY low for 10 cycles
        reset_logs();
        res_delay = 10;
        start_job(2, 3, 'h300, 'h003);
        wait_done("t5");
        res_delay = 0;
        chk("t5_res_cnt", res_lat.size(), 2);
        if (res_lat.size() > 0) chk("t5_res_wait", res_lat[0], 10);
        chk("t5_clr_cnt", clr_cnt, 2);

        // synchronous clear mid-RUN, then a fresh job
        reset_logs();
        start_job(2, 6, 'h400, 'h010);
        t = 0;
        while (!bus.SORT_DAT_VLD && t < 50) begin @(negedge clk); t++; end
        chk("t6_run_timeout", bus.SORT_DAT_VLD, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1 idle_outputs("t6_after_clear");
        repeat (5) @(negedge clk);
        chk("t6_no_done", done_cnt, 0);
        reset_logs();
        start_job(1, 4, 'h010, 0);
        wait_done("t6b");
        e = '{5, 9, 3, 7};      chk_q("t6b_dat", dat_log, e);
        e = '{0};               chk_q("t6b_qry", qry_log, e);

        // async reset mid-OUT, then a fresh job
        reset_logs();
        res_delay = 1000;
        start_job(2, 3, 'h500, 'h001);
        t = 0;
        while (!bus.RES_VLD && t < 100) begin @(negedge clk); t++; end
        chk("t7_out_timeout", bus.RES_VLD, 1);
        rst_n = 1'b0;
        #1 idle_outputs("t7_after_reset");
        @(negedge clk);
        rst_n = 1'b1;
        res_delay = 0;
        repeat (3) @(negedge clk);
        chk("t7_no_done", done_cnt, 0);
        reset_logs();
        start_job(2, 2, 'h100, 'h020);
        wait_done("t7b");
        e = '{'h100, 'h101, 'h120, 'h121}; chk_q("t7b_addr", rd_log, e);
        e = '{0, 1};            chk_q("t7b_qry", qry_log, e);
        chk("t7b_clr_cnt", clr_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
